// File: rtl/eio_timer_responder_pkg.sv
// ---------------------------------------------------------------------------
// eio_timer_responder_pkg
// Shared definitions for the EIO timer responder:
//   - word indices of the eight registers in the EIO window
//   - bit positions inside the CTRL register
//   - handshake FSM state type
//   - byte-enable and lane-merge helpers used by every register write
// ---------------------------------------------------------------------------
package eio_timer_responder_pkg;

    // Word index (addr[4:2]) of each register in the window
    localparam logic [2:0] EIO_SCR0  = 3'd0;
    localparam logic [2:0] EIO_SCR1  = 3'd1;
    localparam logic [2:0] EIO_SCR2  = 3'd2;
    localparam logic [2:0] EIO_SCR3  = 3'd3;
    localparam logic [2:0] EIO_SCR4  = 3'd4;
    localparam logic [2:0] EIO_CTRL  = 3'd5;
    localparam logic [2:0] EIO_COUNT = 3'd6;
    localparam logic [2:0] EIO_CMP   = 3'd7;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_IE_BIT   = 1;
    localparam int CTRL_PEND_BIT = 2;

    typedef enum logic [1:0] {
        EIO_IDLE,
        EIO_WAIT,
        EIO_ACK,
        EIO_GAP
    } eio_state_t;

    // Byte lanes touched by an access of the given size at addr[1:0].
    // Illegal size (3) enables nothing; alignment faults are caught elsewhere.
    function automatic logic [3:0] be_from_size(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replace only the enabled byte lanes of old_word with those of new_word
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/eio_timer_responder_timer.sv
// ---------------------------------------------------------------------------
// eio_timer
// Timer block of the EIO responder: CTRL (en, ie, pend), COUNT and CMP.
// Ports:
//   clk_in, reset_in   clock, asynchronous active-low reset
//   wr_en_in           one-cycle register write strobe from the handshake FSM
//   wr_idx_in          word index of the write (only CTRL/COUNT/CMP act here)
//   wr_be_in           byte enables of the write
//   wr_data_in         lane-aligned write data
//   ctrl_out           CTRL read value {29'b0, pend, ie, en}
//   count_out, cmp_out COUNT and CMP read values
//   irq_out            registered pend & ie
// ---------------------------------------------------------------------------
module eio_timer
    import eio_timer_responder_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        wr_en_in,
    input  logic [2:0]  wr_idx_in,
    input  logic [3:0]  wr_be_in,
    input  logic [31:0] wr_data_in,
    output logic [31:0] ctrl_out,
    output logic [31:0] count_out,
    output logic [31:0] cmp_out,
    output logic        irq_out
);

    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic        irq_q, irq_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;

    // Bus writes override the free-running increment of COUNT in the same
    // cycle. pend is evaluated last so a compare hit beats a W1C clear.
    always_comb begin
        en_d    = en_q;
        ie_d    = ie_q;
        pend_d  = pend_q;
        cmp_d   = cmp_q;
        count_d = en_q ? count_q + 32'd1 : count_q;

        if (wr_en_in) begin
            case (wr_idx_in)
                EIO_CTRL: begin
                    if (wr_be_in[0]) begin
                        en_d = wr_data_in[CTRL_EN_BIT];
                        ie_d = wr_data_in[CTRL_IE_BIT];
                        if (wr_data_in[CTRL_PEND_BIT]) begin
                            pend_d = 1'b0;
                        end
                    end
                end
                EIO_COUNT: count_d = merge_lanes(count_q, wr_data_in, wr_be_in);
                EIO_CMP:   cmp_d   = merge_lanes(cmp_q, wr_data_in, wr_be_in);
                default:   ;
            endcase
        end

        // Compare uses the pre-increment COUNT
        if (en_q && (count_q == cmp_q)) begin
            pend_d = 1'b1;
        end

        irq_d = pend_q & ie_q;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
            count_q <= 32'h0;
            cmp_q   <= 32'h0;
        end else begin
            en_q    <= en_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
        end
    end

    assign ctrl_out  = {29'b0, pend_q, ie_q, en_q};
    assign count_out = count_q;
    assign cmp_out   = cmp_q;
    assign irq_out   = irq_q;

endmodule

// File: rtl/eio_timer_responder.sv
// ---------------------------------------------------------------------------
// eio_timer_responder
// Target end of the EIO request/acknowledge protocol. Decodes a word-aligned
// window of eight registers (SCRATCH0..4, CTRL, COUNT, CMP) and answers each
// request with a one-cycle ack (optionally flagged as a fault).
// Ports:
//   clk_in, reset_in  clock, asynchronous active-low reset
//   req_in            request, held with rd/wr/addr/size/data until ack
//   rd_in, wr_in      command (exactly one must be set)
//   addr_in, size_in  byte address and access size (0 byte, 1 half, 2 word)
//   wr_data_in        lane-aligned write data
//   ack_out           one-cycle completion pulse
//   ack_fault_out     access faulted (no state change)
//   ack_data_out      read word, 0 on write or fault
//   irq_out           timer interrupt, pend & ie, registered
// ---------------------------------------------------------------------------
module eio_timer_responder
    import eio_timer_responder_pkg::*;
#(
    parameter int unsigned     A_SZ        = 32,
    parameter logic [A_SZ-1:0] EIO_BASE    = 32'h0002_0000,
    parameter int unsigned     NUM_REGS    = 8,
    parameter int unsigned     WAIT_STATES = 1
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            req_in,
    input  logic            rd_in,
    input  logic            wr_in,
    input  logic [A_SZ-1:0] addr_in,
    input  logic [1:0]      size_in,
    input  logic [31:0]     wr_data_in,
    output logic            ack_out,
    output logic            ack_fault_out,
    output logic [31:0]     ack_data_out,
    output logic            irq_out
);

    // The window is aligned to its own size, so an upper-bit match is the
    // same as the [base, base+size) range check.
    localparam int unsigned WIN_LSB   = 2 + $clog2(NUM_REGS);
    localparam logic [3:0]  WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    eio_state_t  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        fault_q, fault_d;
    logic        ack_q, ack_d;
    logic        ack_fault_q, ack_fault_d;
    logic [31:0] ack_data_q, ack_data_d;
    logic [31:0] scratch_q [5];
    logic [31:0] scratch_d [5];

    logic        cmd_fault;
    logic [2:0]  sel_idx;
    logic [31:0] rd_word;
    logic        wr_commit;
    logic [31:0] ctrl_word, count_word, cmp_word;

    // Fault decode on the live request fields (used when accepting in IDLE)
    always_comb begin
        cmd_fault = 1'b0;
        if (addr_in[A_SZ-1:WIN_LSB] != EIO_BASE[A_SZ-1:WIN_LSB]) cmd_fault = 1'b1;
        if (rd_in == wr_in)                                     cmd_fault = 1'b1;
        if (size_in == 2'd3)                                    cmd_fault = 1'b1;
        if ((size_in == 2'd1) && addr_in[0])                    cmd_fault = 1'b1;
        if ((size_in == 2'd2) && (addr_in[1:0] != 2'b00))       cmd_fault = 1'b1;
    end

    // With zero wait states the read word is needed while still in IDLE,
    // before the index has been latched.
    assign sel_idx = (state_q == EIO_IDLE) ? addr_in[4:2] : idx_q;

    always_comb begin
        rd_word = 32'h0;
        case (sel_idx)
            EIO_SCR0:  rd_word = scratch_q[0];
            EIO_SCR1:  rd_word = scratch_q[1];
            EIO_SCR2:  rd_word = scratch_q[2];
            EIO_SCR3:  rd_word = scratch_q[3];
            EIO_SCR4:  rd_word = scratch_q[4];
            EIO_CTRL:  rd_word = ctrl_word;
            EIO_COUNT: rd_word = count_word;
            EIO_CMP:   rd_word = cmp_word;
            default:   rd_word = 32'h0;
        endcase
    end

    // Handshake FSM. The ack/fault/data registers are loaded on the edge that
    // enters ACK, so they are high for exactly the ACK cycle.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        fault_d     = fault_q;
        ack_d       = 1'b0;
        ack_fault_d = 1'b0;
        ack_data_d  = 32'h0;

        case (state_q)
            EIO_IDLE: begin
                if (req_in) begin
                    idx_d   = addr_in[4:2];
                    be_d    = be_from_size(size_in, addr_in[1:0]);
                    wdata_d = wr_data_in;
                    wr_d    = wr_in;
                    rd_d    = rd_in;
                    fault_d = cmd_fault;
                    if (WAIT_STATES == 0) begin
                        state_d     = EIO_ACK;
                        ack_d       = 1'b1;
                        ack_fault_d = cmd_fault;
                        ack_data_d  = (cmd_fault || !rd_in) ? 32'h0 : rd_word;
                    end else begin
                        state_d = EIO_WAIT;
                        wcnt_d  = WCNT_INIT;
                    end
                end
            end
            EIO_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d     = EIO_ACK;
                    ack_d       = 1'b1;
                    ack_fault_d = fault_q;
                    ack_data_d  = (fault_q || !rd_q) ? 32'h0 : rd_word;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            EIO_ACK: state_d = EIO_GAP;
            EIO_GAP: state_d = EIO_IDLE;
            default: state_d = EIO_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= EIO_IDLE;
            wcnt_q      <= 4'd0;
            idx_q       <= 3'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'h0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            fault_q     <= 1'b0;
            ack_q       <= 1'b0;
            ack_fault_q <= 1'b0;
            ack_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            idx_q       <= idx_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fault_q     <= fault_d;
            ack_q       <= ack_d;
            ack_fault_q <= ack_fault_d;
            ack_data_q  <= ack_data_d;
        end
    end

    // Writes land on the edge that ends the ACK cycle
    assign wr_commit = (state_q == EIO_ACK) && wr_q && !fault_q;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            scratch_d[i] = scratch_q[i];
            if (wr_commit && (idx_q == 3'(i))) begin
                scratch_d[i] = merge_lanes(scratch_q[i], wdata_q, be_q);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < 5; i++) begin
                scratch_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
        end
    end

    eio_timer u_timer (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .wr_en_in   (wr_commit),
        .wr_idx_in  (idx_q),
        .wr_be_in   (be_q),
        .wr_data_in (wdata_q),
        .ctrl_out   (ctrl_word),
        .count_out  (count_word),
        .cmp_out    (cmp_word),
        .irq_out    (irq_out)
    );

    assign ack_out       = ack_q;
    assign ack_fault_out = ack_fault_q;
    assign ack_data_out  = ack_data_q;

endmodule

// File: tb/tb_eio_timer_responder.sv
// ---------------------------------------------------------------------------
// tb_eio_timer_responder
// Directed bench for eio_timer_responder with WAIT_STATES=1: a table of
// single accesses followed by hand-written timer, reset and GAP sequences.
// ---------------------------------------------------------------------------
module tb_eio_timer_responder;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        req_in;
    logic        rd_in;
    logic        wr_in;
    logic [31:0] addr_in;
    logic [1:0]  size_in;
    logic [31:0] wr_data_in;
    logic        ack_out;
    logic        ack_fault_out;
    logic [31:0] ack_data_out;
    logic        irq_out;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic        exp_fault;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [21];

    eio_timer_responder #(
        .A_SZ        (32),
        .EIO_BASE    (BASE),
        .NUM_REGS    (8),
        .WAIT_STATES (1)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .req_in        (req_in),
        .rd_in         (rd_in),
        .wr_in         (wr_in),
        .addr_in       (addr_in),
        .size_in       (size_in),
        .wr_data_in    (wr_data_in),
        .ack_out       (ack_out),
        .ack_fault_out (ack_fault_out),
        .ack_data_out  (ack_data_out),
        .irq_out       (irq_out)
    );

    always #5 clk_in = ~clk_in;

    // Compare one value and keep the running tallies
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [1:0] size, input logic [31:0] wdata,
                                input logic exp_fault, input logic [31:0] exp_data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
        v.exp_fault = exp_fault; v.exp_data = exp_data;
        return v;
    endfunction

    // Issue one request starting at a negedge with the DUT in IDLE. Returns the
    // number of negedges until ack (-1 on timeout) and the sampled response,
    // and leaves the DUT back in IDLE at a negedge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] wdata,
                                 output int lat, output logic fault, output logic [31:0] data);
        req_in = 1'b1; rd_in = rd; wr_in = wr;
        addr_in = addr; size_in = size; wr_data_in = wdata;
        lat = -1; fault = 1'b0; data = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_in);
            if (ack_out === 1'b1) begin
                lat = i; fault = ack_fault_out; data = ack_data_out;
                break;
            end
        end
        req_in = 1'b0; rd_in = 1'b0; wr_in = 1'b0;
        if (lat < 0) begin
            check_count++;
            $display("[TB] FAIL ack_timeout: no ack within 20 cycles, required ack");
        end else begin
            @(negedge clk_in);
            checkOutput("ack_single_cycle", 32'(ack_out), 32'd0);
            @(negedge clk_in);
        end
    endtask

    task automatic doCheckedAccess(input string name, input logic rd, input logic wr,
                                   input logic [31:0] addr, input logic [1:0] size,
                                   input logic [31:0] wdata, input logic exp_fault,
                                   input logic [31:0] exp_data);
        int          lat;
        logic        f;
        logic [31:0] d;
        applyStimulus(rd, wr, addr, size, wdata, lat, f, d);
        if (lat >= 0) begin
            checkOutput({name, "_latency"}, 32'(lat), 32'd2);
            checkOutput({name, "_fault"}, 32'(f), 32'(exp_fault));
            checkOutput({name, "_data"}, d, exp_data);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int ack_seen;

        //           rd    wr    addr          sz    wdata          flt   data
        vecs[0]  = mk(1'b0, 1'b1, BASE + 32'h04, 2'd2, 32'hDEADBEEF, 1'b0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b0, BASE + 32'h04, 2'd2, 32'h0,        1'b0, 32'hDEADBEEF);
        vecs[2]  = mk(1'b0, 1'b1, BASE + 32'h06, 2'd0, 32'h00A50000, 1'b0, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, BASE + 32'h04, 2'd2, 32'h0,        1'b0, 32'hDEA5BEEF);
        vecs[4]  = mk(1'b0, 1'b1, BASE + 32'h0A, 2'd1, 32'h12340000, 1'b0, 32'h0);
        vecs[5]  = mk(1'b1, 1'b0, BASE + 32'h08, 2'd2, 32'h0,        1'b0, 32'h12340000);
        vecs[6]  = mk(1'b0, 1'b1, BASE + 32'h20, 2'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
        vecs[7]  = mk(1'b1, 1'b0, BASE + 32'h01, 2'd2, 32'h0,        1'b1, 32'h0);
        vecs[8]  = mk(1'b1, 1'b1, BASE + 32'h04, 2'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
        vecs[9]  = mk(1'b0, 1'b1, BASE + 32'h05, 2'd1, 32'hFFFFFFFF, 1'b1, 32'h0);
        vecs[10] = mk(1'b1, 1'b0, BASE + 32'h04, 2'd2, 32'h0,        1'b0, 32'hDEA5BEEF);
        vecs[11] = mk(1'b1, 1'b0, BASE + 32'h00, 2'd2, 32'h0,        1'b0, 32'h0);
        vecs[12] = mk(1'b1, 1'b0, BASE + 32'h00, 2'd3, 32'h0,        1'b1, 32'h0);
        vecs[13] = mk(1'b0, 1'b0, BASE + 32'h00, 2'd2, 32'h0,        1'b1, 32'h0);
        vecs[14] = mk(1'b0, 1'b1, BASE - 32'h04, 2'd2, 32'h11111111, 1'b1, 32'h0);
        vecs[15] = mk(1'b0, 1'b1, BASE + 32'h10, 2'd2, 32'hCAFEF00D, 1'b0, 32'h0);
        vecs[16] = mk(1'b1, 1'b0, BASE + 32'h10, 2'd2, 32'h0,        1'b0, 32'hCAFEF00D);
        vecs[17] = mk(1'b1, 1'b0, BASE + 32'h07, 2'd0, 32'h0,        1'b0, 32'hDEA5BEEF);
        vecs[18] = mk(1'b1, 1'b0, BASE + 32'h1C, 2'd2, 32'h0,        1'b0, 32'h0);
        vecs[19] = mk(1'b1, 1'b0, BASE + 32'h14, 2'd2, 32'h0,        1'b0, 32'h0);
        vecs[20] = mk(1'b1, 1'b0, BASE + 32'h0A, 2'd1, 32'h0,        1'b0, 32'h12340000);

        reset_in = 1'b0; req_in = 1'b0; rd_in = 1'b0; wr_in = 1'b0;
        addr_in = 32'h0; size_in = 2'd0; wr_data_in = 32'h0;
        repeat (3) @(negedge clk_in);
        checkOutput("reset_ack", 32'(ack_out), 32'd0);
        checkOutput("reset_fault", 32'(ack_fault_out), 32'd0);
        checkOutput("reset_data", ack_data_out, 32'h0);
        checkOutput("reset_irq", 32'(irq_out), 32'd0);
        reset_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 21; i++) begin
            doCheckedAccess($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                            vecs[i].size, vecs[i].wdata, vecs[i].exp_fault, vecs[i].exp_data);
        end

        // Timer compare: COUNT starts at 0 when CTRL=3 lands; pend sets on the
        // edge after COUNT reaches 10 and irq follows one edge later.
        doCheckedAccess("cmp_wr", 1'b0, 1'b1, BASE + 32'h1C, 2'd2, 32'd10, 1'b0, 32'h0);
        doCheckedAccess("ctrl_en_ie", 1'b0, 1'b1, BASE + 32'h14, 2'd2, 32'h3, 1'b0, 32'h0);
        repeat (10) @(negedge clk_in);
        checkOutput("irq_before_edge", 32'(irq_out), 32'd0);
        @(negedge clk_in);
        checkOutput("irq_asserted", 32'(irq_out), 32'd1);
        doCheckedAccess("ctrl_pending", 1'b1, 1'b0, BASE + 32'h14, 2'd2, 32'h0, 1'b0, 32'h7);
        doCheckedAccess("ctrl_w1c", 1'b0, 1'b1, BASE + 32'h14, 2'd2, 32'h4, 1'b0, 32'h0);
        checkOutput("irq_cleared", 32'(irq_out), 32'd0);
        doCheckedAccess("ctrl_after_w1c", 1'b1, 1'b0, BASE + 32'h14, 2'd2, 32'h0, 1'b0, 32'h0);

        // COUNT wrap and write-over-increment
        doCheckedAccess("count_wr", 1'b0, 1'b1, BASE + 32'h18, 2'd2, 32'hFFFFFFFE, 1'b0, 32'h0);
        doCheckedAccess("count_idle", 1'b1, 1'b0, BASE + 32'h18, 2'd2, 32'h0, 1'b0, 32'hFFFFFFFE);
        doCheckedAccess("ctrl_en", 1'b0, 1'b1, BASE + 32'h14, 2'd2, 32'h1, 1'b0, 32'h0);
        doCheckedAccess("count_wrap0", 1'b1, 1'b0, BASE + 32'h18, 2'd2, 32'h0, 1'b0, 32'h0);
        doCheckedAccess("count_wrap4", 1'b1, 1'b0, BASE + 32'h18, 2'd2, 32'h0, 1'b0, 32'h4);
        doCheckedAccess("count_wr5", 1'b0, 1'b1, BASE + 32'h18, 2'd2, 32'h5, 1'b0, 32'h0);
        doCheckedAccess("count_after5", 1'b1, 1'b0, BASE + 32'h18, 2'd2, 32'h0, 1'b0, 32'h7);

        // Reset while the access sits in WAIT: it must vanish without an ack
        req_in = 1'b1; rd_in = 1'b1; wr_in = 1'b0;
        addr_in = BASE + 32'h04; size_in = 2'd2;
        @(negedge clk_in);
        reset_in = 1'b0; req_in = 1'b0; rd_in = 1'b0;
        #1;
        checkOutput("rst_wait_ack", 32'(ack_out), 32'd0);
        checkOutput("rst_wait_fault", 32'(ack_fault_out), 32'd0);
        checkOutput("rst_wait_data", ack_data_out, 32'h0);
        checkOutput("rst_wait_irq", 32'(irq_out), 32'd0);
        ack_seen = 0;
        repeat (4) begin
            @(negedge clk_in);
            if (ack_out === 1'b1) ack_seen++;
        end
        reset_in = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            if (ack_out === 1'b1) ack_seen++;
        end
        checkOutput("rst_no_ack", 32'(ack_seen), 32'd0);
        doCheckedAccess("post_rst_scr1", 1'b1, 1'b0, BASE + 32'h04, 2'd2, 32'h0, 1'b0, 32'h0);
        doCheckedAccess("post_rst_count", 1'b1, 1'b0, BASE + 32'h18, 2'd2, 32'h0, 1'b0, 32'h0);
        doCheckedAccess("post_rst_ctrl", 1'b1, 1'b0, BASE + 32'h14, 2'd2, 32'h0, 1'b0, 32'h0);

        // Request held through GAP: one ack only, GAP cycle must not re-accept
        req_in = 1'b1; rd_in = 1'b1; wr_in = 1'b0;
        addr_in = BASE + 32'h04; size_in = 2'd2;
        ack_seen = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_in);
            if (ack_out === 1'b1) ack_seen++;
            if (i == 3) checkOutput("gap_no_ack", 32'(ack_out), 32'd0);
            if (i == 4) begin
                req_in = 1'b0; rd_in = 1'b0;
            end
        end
        checkOutput("held_req_one_ack", 32'(ack_seen), 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
